// File: rtl/ps2_frame_rx_pkg.sv
// Shared types and scan-code constants for the PS/2 frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXTEND = 8'hE0;
    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;

    // PS/2 uses odd parity: data bits plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// Decoded key event bus from the PS/2 frame receiver to its consumer.
interface ps2_frame_rx_if;
    logic [7:0] key_in;
    logic       is_extend;
    logic       is_break;
    logic       valid;
    logic       err;

    modport master (output key_in, is_extend, is_break, valid, err);
    modport slave  (input  key_in, is_extend, is_break, valid, err);
endinterface

// File: rtl/ps2_frame_rx_clk_filter.sv
// Two-flop synchronisers for the PS/2 lines plus a run-length filter on the
// clock that yields a clean level and a one-cycle fall strobe.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_filt,
    output logic fall,
    output logic data_sync
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    clk_ff;
    logic [1:0]    data_ff;
    logic [CW-1:0] filt_cnt;

    assign data_sync = data_ff[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            filt_cnt <= '0;
            clk_filt <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_ff  <= {clk_ff[0], ps2_clk};
            data_ff <= {data_ff[0], ps2_data};
            fall    <= 1'b0;
            // Count samples that disagree with the filtered level; any agreeing
            // sample restarts the run so short glitches never flip the level.
            if (clk_ff[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == CW'(FILT_LEN - 1)) begin
                clk_filt <= clk_ff[1];
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver with E0/F0 prefix folding.
// Optional parity enforcement: define PS2_RX_PARITY_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit (data 0 on a clock fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit and issuing the result
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int FILT_LEN    = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_frame_rx_if.master kb
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] DATA   = ST_DATA;
    localparam logic [1:0] PARITY = ST_PARITY;
    localparam logic [1:0] STOP   = ST_STOP;

    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

    logic          filt_lvl_unused;
    logic          fall;
    logic          data_sync;
    logic [1:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] tmo_cnt;
    logic          ext;
    logic          brk;
    logic          frame_ok;
    logic [7:0]    key_r;
    logic          ext_r;
    logic          brk_r;
    logic          valid_r;
    logic          err_r;

    ps2_clk_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_filt  (filt_lvl_unused),
        .fall      (fall),
        .data_sync (data_sync)
    );

`ifdef PS2_RX_PARITY_CHECK_EN
    logic par_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_ok <= 1'b0;
        end else if (fall && state == PARITY) begin
            par_ok <= odd_parity_ok(shift, data_sync);
        end
    end

    assign frame_ok = data_sync & par_ok;
`else
    // Parity bit is clocked through the PARITY state but never judged.
    assign frame_ok = data_sync;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            tmo_cnt <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            key_r   <= 8'h00;
            ext_r   <= 1'b0;
            brk_r   <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;

            if (state == IDLE || fall) begin
                tmo_cnt <= TMO_LOAD;
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_sync) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift <= {data_sync, shift[7:1]};
                        if (bit_cnt == 4'd7) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (!frame_ok) begin
                            err_r <= 1'b1;
                            ext   <= 1'b0;
                            brk   <= 1'b0;
                        end else if (shift == PS2_EXTEND) begin
                            ext <= 1'b1;
                        end else if (shift == PS2_BREAK) begin
                            brk <= 1'b1;
                        end else begin
                            key_r   <= shift;
                            ext_r   <= ext;
                            brk_r   <= brk;
                            valid_r <= 1'b1;
                            ext     <= 1'b0;
                            brk     <= 1'b0;
                        end
                    end
                endcase
            end else if (state != IDLE && tmo_cnt == '0) begin
                // Keyboard stopped clocking mid-frame: drop it and any pending prefix.
                state <= IDLE;
                err_r <= 1'b1;
                ext   <= 1'b0;
                brk   <= 1'b0;
            end
        end
    end

    assign kb.key_in    = key_r;
    assign kb.is_extend = ext_r;
    assign kb.is_break  = brk_r;
    assign kb.valid     = valid_r;
    assign kb.err       = err_r;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: table of whole frames plus hand-written
// timeout, mid-frame reset, glitch and stray-start sequences.
module tb_ps2_frame_rx;

    localparam int TMO  = 2000;
    localparam int HALF = 40;
    localparam int NV   = 12;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    always #5 clk = ~clk;

    ps2_frame_rx_if kb ();

    ps2_frame_rx #(
        .TIMEOUT_CYC (TMO),
        .FILT_LEN    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kb       (kb)
    );

    int cyc = 0;
    int tot_valid = 0;
    int tot_err = 0;
    int tot_both = 0;
    int last_pulse_cyc = 0;
    int stop_cyc = 0;
    int n_cmp = 0;
    int n_mis = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (kb.valid) begin
            tot_valid++;
            last_pulse_cyc = cyc;
        end
        if (kb.err) begin
            tot_err++;
            last_pulse_cyc = cyc;
        end
        if (kb.valid && kb.err) tot_both++;
    end

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        logic       stop_v;
        int         exp_v;
        int         exp_e;
        logic [7:0] exp_key;
        logic       exp_ext;
        logic       exp_brk;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch, input bit is_stop);
        @(negedge clk);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(20);
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(HALF - 23);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b0;
        if (is_stop) stop_cyc = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop_v,
                              input int nbits, input bit glitch);
        logic par;
        par = (~^d) ^ bad_par;
        send_bit(1'b0, glitch, 1'b0);
        for (int i = 0; i < 8 && i < nbits; i++) send_bit(d[i], glitch, 1'b0);
        if (nbits >= 8) begin
            send_bit(par, glitch, 1'b0);
            send_bit(stop_v, glitch, 1'b1);
        end
    endtask

    task automatic check_outputs(input string tag, input int v0, input int e0, input int exp_v,
                                 input int exp_e, input logic [7:0] key, input logic ext,
                                 input logic brk);
        check({tag, "_valid"}, tot_valid - v0, exp_v);
        check({tag, "_err"}, tot_err - e0, exp_e);
        check({tag, "_key"}, {24'h0, kb.key_in}, {24'h0, key});
        check({tag, "_ext"}, {31'h0, kb.is_extend}, {31'h0, ext});
        check({tag, "_brk"}, {31'h0, kb.is_break}, {31'h0, brk});
    endtask

    initial begin
        int v0;
        int e0;

        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[1]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[3]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b1, 1'b1};
        vecs[4]  = '{8'h4D, 1'b0, 1'b0, 0, 1, 8'h75, 1'b1, 1'b1};
        vecs[5]  = '{8'h4D, 1'b0, 1'b1, 1, 0, 8'h4D, 1'b0, 1'b0};
        vecs[6]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h4D, 1'b0, 1'b0};
        vecs[7]  = '{8'h5A, 1'b0, 1'b0, 0, 1, 8'h4D, 1'b0, 1'b0};
        vecs[8]  = '{8'h12, 1'b0, 1'b1, 1, 0, 8'h12, 1'b0, 1'b0};
        vecs[9]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h12, 1'b0, 1'b0};
        vecs[10] = '{8'h12, 1'b0, 1'b1, 1, 0, 8'h12, 1'b0, 1'b1};
`ifdef PS2_RX_PARITY_CHECK_EN
        vecs[11] = '{8'h29, 1'b1, 1'b1, 0, 1, 8'h12, 1'b0, 1'b1};
`else
        vecs[11] = '{8'h29, 1'b1, 1'b1, 1, 0, 8'h29, 1'b0, 1'b0};
`endif

        rst = 1'b0;
        wait_cyc(5);
        check_outputs("reset", tot_valid, tot_err, 0, 0, 8'h00, 1'b0, 1'b0);
        check("reset_valid_pin", {31'h0, kb.valid}, 32'd0);
        check("reset_err_pin", {31'h0, kb.err}, 32'd0);
        rst = 1'b1;
        wait_cyc(20);

        for (int i = 0; i < NV; i++) begin
            v0 = tot_valid;
            e0 = tot_err;
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop_v, 8, 1'b0);
            wait_cyc(30);
            check_outputs($sformatf("vec%0d", i), v0, e0, vecs[i].exp_v, vecs[i].exp_e,
                          vecs[i].exp_key, vecs[i].exp_ext, vecs[i].exp_brk);
            if (vecs[i].exp_v + vecs[i].exp_e == 1)
                check($sformatf("vec%0d_latency", i), last_pulse_cyc - stop_cyc, 11);
        end

        // Stray fall with data high while idle must be ignored.
        v0 = tot_valid;
        e0 = tot_err;
        send_bit(1'b1, 1'b0, 1'b0);
        wait_cyc(TMO + 200);
        check("stray_valid", tot_valid - v0, 0);
        check("stray_err", tot_err - e0, 0);
        v0 = tot_valid;
        e0 = tot_err;
        send_frame(8'h21, 1'b0, 1'b1, 8, 1'b0);
        wait_cyc(30);
        check_outputs("after_stray", v0, e0, 1, 0, 8'h21, 1'b0, 1'b0);

        // Keyboard stalls after four data bits.
        v0 = tot_valid;
        e0 = tot_err;
        send_frame(8'h3C, 1'b0, 1'b1, 4, 1'b0);
        wait_cyc(TMO + 200);
        check_outputs("timeout", v0, e0, 0, 1, 8'h21, 1'b0, 1'b0);
        v0 = tot_valid;
        e0 = tot_err;
        send_frame(8'hAA, 1'b0, 1'b1, 8, 1'b0);
        wait_cyc(30);
        check_outputs("after_timeout", v0, e0, 1, 0, 8'hAA, 1'b0, 1'b0);

        // Pending E0 prefix, then reset in the middle of another E0 frame.
        send_frame(8'hE0, 1'b0, 1'b1, 8, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b1, 6, 1'b0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(3);
        check_outputs("midreset", tot_valid, tot_err, 0, 0, 8'h00, 1'b0, 1'b0);
        check("midreset_valid_pin", {31'h0, kb.valid}, 32'd0);
        check("midreset_err_pin", {31'h0, kb.err}, 32'd0);
        rst = 1'b1;
        wait_cyc(20);
        v0 = tot_valid;
        e0 = tot_err;
        send_frame(8'h6B, 1'b0, 1'b1, 8, 1'b0);
        wait_cyc(30);
        check_outputs("after_reset", v0, e0, 1, 0, 8'h6B, 1'b0, 1'b0);

        // Three-cycle low glitches in every clock-high phase.
        v0 = tot_valid;
        e0 = tot_err;
        send_frame(8'h33, 1'b0, 1'b1, 8, 1'b1);
        wait_cyc(30);
        check_outputs("glitch", v0, e0, 1, 0, 8'h33, 1'b0, 1'b0);

        check("valid_err_overlap", tot_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
